bram_asym_sdp: RTL and testbench
================================

BRAM_ASYM_SDP -- requirements
Module: bram_asym_sdp

Interface
REQ-001 SHALL have parameter WR_WIDTH, default 16: write data width in bits.
REQ-002 SHALL have parameter RD_WIDTH, default 32: read data width in bits.
REQ-003 SHALL have parameter WR_DEPTH, default 2048: number of write-side words.
REQ-004 SHALL have parameter OUT_REG, default 0: 1 adds an output pipeline stage.
REQ-005 SHALL derive the following values: RD_DEPTH = WR_DEPTH*WR_WIDTH/RD_WIDTH; WA_W = $clog2(WR_DEPTH); RA_W = $clog2(RD_DEPTH).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port wce, input, 1 bit: write enable.
REQ-009 SHALL have port wa, input, WA_W bits: write address in write-width units.
REQ-010 SHALL have port wd, input, WR_WIDTH bits: write data.
REQ-011 SHALL have port rce, input, 1 bit: read enable.
REQ-012 SHALL have port ra, input, RA_W bits: read address in read-width units.
REQ-013 SHALL have port rq, output, RD_WIDTH bits: registered read data.
REQ-014 SHALL have port rq_valid, output, 1 bit: high for one cycle when rq carries the data for an accepted rce.

Function
REQ-015 SHALL store data as MEM_DEPTH words of W = max(WR_WIDTH, RD_WIDTH) bits; R = W/min(WR_WIDTH, RD_WIDTH); MEM_DEPTH = WR_DEPTH*WR_WIDTH/W.
REQ-016 SHALL accept only R in {1,2,4} with WR_DEPTH a power of two; any other combination SHALL stop elaboration with an error.
REQ-017 Wider-read mode (RD_WIDTH > WR_WIDTH): a write SHALL update lane (wa % R) of word wa/R, bits [(wa%R)*WR_WIDTH +: WR_WIDTH], leaving the other lanes unchanged.
REQ-018 Wider-write mode (WR_WIDTH > RD_WIDTH): a read SHALL return lane (ra % R) of word ra/R; a write SHALL replace the whole word wa.
REQ-019 Equal widths (R=1): the block SHALL behave as a plain simple-dual-port RAM.
REQ-020 Lane 0 SHALL be the least-significant lane, so the lowest narrow address maps to the LSBs.
REQ-021 Read latency SHALL be 1 cycle when OUT_REG=0 and 2 cycles when OUT_REG=1, measured from the rce edge to rq/rq_valid.
REQ-022 When rce=0, rq SHALL hold its previous value and rq_valid SHALL be 0 in the corresponding cycle; the OUT_REG stage SHALL advance only when its input is valid.
REQ-023 Read and write to the same word in the same cycle SHALL be read-first: rq returns the pre-write contents, and the new data is visible from the next read.
REQ-024 Back-to-back reads SHALL be accepted every cycle with no bubbles.
REQ-025 Addresses SHALL be taken modulo the depth; out-of-range addresses SHALL be impossible by construction of the port widths.
REQ-026 Memory contents SHALL initialise to all zeros at time zero.

Reset
REQ-027 rst SHALL clear rq, rq_valid and any OUT_REG stage to 0 asynchronously.
REQ-028 rst SHALL NOT alter memory contents.
REQ-029 A read issued in the cycle rst deasserts SHALL complete normally.
REQ-030 Reads in flight when rst asserts SHALL be discarded, with no rq_valid produced.
REQ-031 Writes SHALL be ignored while rst=1.

Structure
REQ-032 Package bram_asym_pkg SHALL hold the legal-ratio check function, a lane-select helper function, and the derived-width localparams.
REQ-033 The optional output stage SHALL be a single sub-module, bram_asym_outreg (data plus valid, async reset), instantiated under a generate on OUT_REG.

Verification
REQ-034 Config 16->32, WR_DEPTH 2048: write wa=6 wd=16'hBEEF, then wa=7 wd=16'hCAFE; read ra=3 -> rq=32'hCAFEBEEF with rq_valid 1 cycle after rce.
REQ-035 Config 32->8, WR_DEPTH 1024: write wa=5 wd=32'h44332211; read ra=20..23 back-to-back -> rq=8'h11,8'h22,8'h33,8'h44 on consecutive cycles.
REQ-036 Config 8->32, wa=8 wd=8'hAA, with a simultaneous read ra=2 (word previously 0) -> rq=0; next read ra=2 -> 32'h000000AA.
REQ-037 OUT_REG=1: rce pulse at cycle N -> rq_valid only at N+2; rce held low -> rq holds its value and rq_valid stays 0.
REQ-038 Assert rst with a read in flight -> rq=0, rq_valid=0 immediately with no valid pulse; after rst deasserts, earlier written data SHALL read back intact.
REQ-039 Illegal configuration WR_WIDTH=8, RD_WIDTH=24 -> elaboration SHALL fail.

Source files
------------

// File: rtl/bram_asym_pkg.sv
// Shared helpers for the asymmetric simple-dual-port block RAM:
// ratio legality, lane positioning and default derived widths.
package bram_asym_pkg;

    localparam int unsigned DEF_WR_WIDTH = 16;
    localparam int unsigned DEF_RD_WIDTH = 32;
    localparam int unsigned DEF_WR_DEPTH = 2048;
    localparam int unsigned DEF_W        = (DEF_WR_WIDTH > DEF_RD_WIDTH) ? DEF_WR_WIDTH : DEF_RD_WIDTH;
    localparam int unsigned DEF_N        = (DEF_WR_WIDTH > DEF_RD_WIDTH) ? DEF_RD_WIDTH : DEF_WR_WIDTH;
    localparam int unsigned DEF_R        = DEF_W / DEF_N;

    function automatic int unsigned wide_w(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned narrow_w(input int unsigned a, input int unsigned b);
        return (a > b) ? b : a;
    endfunction

    // Legal only for lane ratios 1/2/4, power-of-two depth and at least two storage words.
    function automatic bit legal_ratio(input int unsigned wr_w, input int unsigned rd_w,
                                       input int unsigned wr_depth);
        int unsigned w;
        int unsigned n;
        int unsigned r;
        w = wide_w(wr_w, rd_w);
        n = narrow_w(wr_w, rd_w);
        if (n == 0) return 1'b0;
        if ((w % n) != 0) return 1'b0;
        r = w / n;
        if (!(r inside {1, 2, 4})) return 1'b0;
        if (wr_depth < 2 || (wr_depth & (wr_depth - 1)) != 0) return 1'b0;
        if ((wr_depth * wr_w / w) < 2) return 1'b0;
        return 1'b1;
    endfunction

    // LSB position of the narrow lane addressed by addr; lane 0 sits at the word LSBs.
    function automatic int unsigned lane_lsb(input int unsigned addr, input int unsigned r,
                                             input int unsigned lane_w);
        return (addr & (r - 1)) * lane_w;
    endfunction

endpackage

// File: rtl/bram_asym_outreg.sv
// Optional output pipeline stage: captures data only when its input is valid.
module bram_asym_outreg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            q_valid <= d_valid;
            if (d_valid) q <= d;
        end
    end

endmodule

// File: rtl/bram_asym_sdp.sv
// Asymmetric-width simple-dual-port RAM: one write port and one read port of
// different widths sharing a single clock, read-first on address collision.
module bram_asym_sdp
    import bram_asym_pkg::*;
#(
    parameter  int unsigned WR_WIDTH = DEF_WR_WIDTH,
    parameter  int unsigned RD_WIDTH = DEF_RD_WIDTH,
    parameter  int unsigned WR_DEPTH = DEF_WR_DEPTH,
    parameter  int unsigned OUT_REG  = 0,
    localparam int unsigned RD_DEPTH = WR_DEPTH * WR_WIDTH / RD_WIDTH,
    localparam int unsigned WA_W     = $clog2(WR_DEPTH),
    localparam int unsigned RA_W     = $clog2(RD_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wce,
    input  logic [WA_W-1:0]     wa,
    input  logic [WR_WIDTH-1:0] wd,
    input  logic                rce,
    input  logic [RA_W-1:0]     ra,
    output logic [RD_WIDTH-1:0] rq,
    output logic                rq_valid
);

    localparam int unsigned W         = wide_w(WR_WIDTH, RD_WIDTH);
    localparam int unsigned N         = narrow_w(WR_WIDTH, RD_WIDTH);
    localparam int unsigned R         = (N == 0) ? 1 : W / N;
    localparam int unsigned MEM_DEPTH = WR_DEPTH * WR_WIDTH / W;
    localparam int unsigned MA_W      = $clog2(MEM_DEPTH);
    localparam int unsigned SH        = $clog2(R);
    localparam int unsigned LSB_W     = $clog2(W);

    if (!legal_ratio(WR_WIDTH, RD_WIDTH, WR_DEPTH)) begin : g_illegal
        $error("bram_asym_sdp: unsupported width ratio or depth");
    end

    logic [W-1:0]        mem [MEM_DEPTH] = '{default: '0};
    logic [RD_WIDTH-1:0] rdata;
    logic [RD_WIDTH-1:0] rq_s1;
    logic                valid_s1;

    // Write port: lane update when the read side is wider, whole word otherwise.
    if (RD_WIDTH > WR_WIDTH) begin : g_lane_wr
        logic [MA_W-1:0]  w_word;
        logic [LSB_W-1:0] w_lsb;
        assign w_word = MA_W'(wa >> SH);
        assign w_lsb  = LSB_W'(lane_lsb(32'(wa), R, WR_WIDTH));
        always_ff @(posedge clk) begin
            if (wce && !rst) mem[w_word][w_lsb +: WR_WIDTH] <= wd;
        end
    end else begin : g_word_wr
        always_ff @(posedge clk) begin
            if (wce && !rst) mem[MA_W'(wa)] <= wd;
        end
    end

    // Read port: lane extract when the write side is wider, whole word otherwise.
    if (WR_WIDTH > RD_WIDTH) begin : g_lane_rd
        logic [MA_W-1:0]  r_word;
        logic [LSB_W-1:0] r_lsb;
        assign r_word = MA_W'(ra >> SH);
        assign r_lsb  = LSB_W'(lane_lsb(32'(ra), R, RD_WIDTH));
        assign rdata  = mem[r_word][r_lsb +: RD_WIDTH];
    end else begin : g_word_rd
        assign rdata = mem[MA_W'(ra)];
    end

    // First read register; sampling pre-edge contents gives read-first collisions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rq_s1    <= '0;
            valid_s1 <= 1'b0;
        end else begin
            valid_s1 <= rce;
            if (rce) rq_s1 <= rdata;
        end
    end

    if (OUT_REG != 0) begin : g_outreg
        bram_asym_outreg #(.WIDTH(RD_WIDTH)) u_outreg (
            .clk     (clk),
            .rst     (rst),
            .d       (rq_s1),
            .d_valid (valid_s1),
            .q       (rq),
            .q_valid (rq_valid)
        );
    end else begin : g_no_outreg
        assign rq       = rq_s1;
        assign rq_valid = valid_s1;
    end

endmodule

// File: tb/tb_bram_asym_sdp.sv
// Scoreboard bench for bram_asym_sdp across four width/pipeline configurations.
module tb_bram_asym_sdp;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // u0: 16->32 depth 2048; u1: 32->8 depth 1024; u2: 8->32 depth 2048; u3: 16->32 OUT_REG=1
    logic        wce0, rce0, rq_valid0;
    logic [10:0] wa0;
    logic [15:0] wd0;
    logic [9:0]  ra0;
    logic [31:0] rq0;

    logic        wce1, rce1, rq_valid1;
    logic [9:0]  wa1;
    logic [31:0] wd1;
    logic [11:0] ra1;
    logic [7:0]  rq1;

    logic        wce2, rce2, rq_valid2;
    logic [10:0] wa2;
    logic [7:0]  wd2;
    logic [8:0]  ra2;
    logic [31:0] rq2;

    logic        wce3, rce3, rq_valid3;
    logic [10:0] wa3;
    logic [15:0] wd3;
    logic [9:0]  ra3;
    logic [31:0] rq3;

    bram_asym_sdp #(.WR_WIDTH(16), .RD_WIDTH(32), .WR_DEPTH(2048), .OUT_REG(0)) u0 (
        .clk(clk), .rst(rst), .wce(wce0), .wa(wa0), .wd(wd0),
        .rce(rce0), .ra(ra0), .rq(rq0), .rq_valid(rq_valid0));
    bram_asym_sdp #(.WR_WIDTH(32), .RD_WIDTH(8), .WR_DEPTH(1024), .OUT_REG(0)) u1 (
        .clk(clk), .rst(rst), .wce(wce1), .wa(wa1), .wd(wd1),
        .rce(rce1), .ra(ra1), .rq(rq1), .rq_valid(rq_valid1));
    bram_asym_sdp #(.WR_WIDTH(8), .RD_WIDTH(32), .WR_DEPTH(2048), .OUT_REG(0)) u2 (
        .clk(clk), .rst(rst), .wce(wce2), .wa(wa2), .wd(wd2),
        .rce(rce2), .ra(ra2), .rq(rq2), .rq_valid(rq_valid2));
    bram_asym_sdp #(.WR_WIDTH(16), .RD_WIDTH(32), .WR_DEPTH(2048), .OUT_REG(1)) u3 (
        .clk(clk), .rst(rst), .wce(wce3), .wa(wa3), .wd(wd3),
        .rce(rce3), .ra(ra3), .rq(rq3), .rq_valid(rq_valid3));

    logic [31:0] rqw [4];
    logic        vw  [4];
    always_comb begin
        rqw[0] = rq0;
        rqw[1] = 32'(rq1);
        rqw[2] = rq2;
        rqw[3] = rq3;
        vw[0]  = rq_valid0;
        vw[1]  = rq_valid1;
        vw[2]  = rq_valid2;
        vw[3]  = rq_valid3;
    end

    exp_t sb [4][$];
    int   cyc;
    int   checks;
    int   errors;

    task automatic clear_inputs();
        wce0 = 0; rce0 = 0; wce1 = 0; rce1 = 0;
        wce2 = 0; rce2 = 0; wce3 = 0; rce3 = 0;
    endtask

    // One clock: scoreboard compare at negedge, then advance past posedge and idle enables.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sb[i].size() > 0 && sb[i][0].cyc == cyc) begin
                if (vw[i] !== 1'b1 || rqw[i] !== sb[i][0].data) begin
                    errors++;
                    $display("FAIL sb_u%0d cyc %0d: rq_valid=%b rq=%h, required rq_valid=1 rq=%h",
                             i, cyc, vw[i], rqw[i], sb[i][0].data);
                end
                void'(sb[i].pop_front());
            end else if (vw[i] !== 1'b0) begin
                errors++;
                $display("FAIL sb_u%0d cyc %0d: rq_valid=%b rq=%h, required rq_valid=0",
                         i, cyc, vw[i], rqw[i]);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        clear_inputs();
    endtask

    task automatic wr(input int inst, input int a, input logic [31:0] d);
        case (inst)
            0: begin wce0 = 1; wa0 = 11'(a); wd0 = d[15:0]; end
            1: begin wce1 = 1; wa1 = 10'(a); wd1 = d;       end
            2: begin wce2 = 1; wa2 = 11'(a); wd2 = d[7:0];  end
            default: begin wce3 = 1; wa3 = 11'(a); wd3 = d[15:0]; end
        endcase
    endtask

    task automatic rd(input int inst, input int a, input logic [31:0] e, input bit push = 1'b1);
        exp_t x;
        case (inst)
            0: begin rce0 = 1; ra0 = 10'(a); end
            1: begin rce1 = 1; ra1 = 12'(a); end
            2: begin rce2 = 1; ra2 = 9'(a);  end
            default: begin rce3 = 1; ra3 = 10'(a); end
        endcase
        if (push) begin
            x.cyc  = cyc + 1 + ((inst == 3) ? 1 : 0);
            x.data = e;
            sb[inst].push_back(x);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rqw[i] !== 32'h0 || vw[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_u%0d: rq=%h rq_valid=%b, required 0/0", i, rqw[i], vw[i]);
            end
        end
    endtask

    task automatic test_wide_read();
        rd(0, 3, 32'h0);
        tick();
        wr(0, 6, 32'hBEEF);
        tick();
        wr(0, 7, 32'hCAFE);
        tick();
        rd(0, 3, 32'hCAFEBEEF);
        tick();
        wr(0, 0, 32'h1234);
        rd(0, 1, 32'h0);
        tick();
        rd(0, 0, 32'h00001234);
        tick();
        tick();
    endtask

    task automatic test_wide_write();
        logic [31:0] lanes [4];
        lanes[0] = 32'h11; lanes[1] = 32'h22; lanes[2] = 32'h33; lanes[3] = 32'h44;
        wr(1, 5, 32'h44332211);
        tick();
        for (int a = 20; a < 24; a++) begin
            rd(1, a, lanes[a - 20]);
            tick();
        end
        tick();
    endtask

    task automatic test_read_first();
        wr(2, 8, 32'hAA);
        rd(2, 2, 32'h0);
        tick();
        rd(2, 2, 32'h000000AA);
        tick();
        wr(2, 11, 32'h55);
        tick();
        rd(2, 2, 32'h550000AA);
        tick();
        tick();
    endtask

    task automatic test_out_reg();
        wr(3, 2, 32'h1111);
        tick();
        wr(3, 3, 32'h2222);
        tick();
        rd(3, 1, 32'h22221111);
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (rq3 !== 32'h22221111 || rq_valid3 !== 1'b0) begin
                errors++;
                $display("FAIL outreg_hold k%0d: rq=%h rq_valid=%b, required 22221111/0",
                         k, rq3, rq_valid3);
            end
        end
    endtask

    task automatic test_back_to_back();
        rd(3, 1, 32'h22221111);
        tick();
        rd(3, 0, 32'h0);
        tick();
        rd(3, 1, 32'h22221111);
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset_inflight();
        rd(3, 1, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        cyc++;
        clear_inputs();
        rst = 1'b1;
        wr(0, 6, 32'h0);
        #1;
        checks++;
        if (rq3 !== 32'h0 || rq_valid3 !== 1'b0 || rq0 !== 32'h0 || rq_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_inflight: u3 rq=%h v=%b u0 rq=%h v=%b, required all 0",
                     rq3, rq_valid3, rq0, rq_valid0);
        end
        tick();
        tick();
        rst = 1'b0;
        rd(3, 1, 32'h22221111);
        rd(0, 3, 32'hCAFEBEEF);
        tick();
        rd(2, 2, 32'h550000AA);
        tick();
        tick();
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        clear_inputs();
        wa0 = '0; wd0 = '0; ra0 = '0;
        wa1 = '0; wd1 = '0; ra1 = '0;
        wa2 = '0; wd2 = '0; ra2 = '0;
        wa3 = '0; wd3 = '0; ra3 = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_wide_read();
        test_wide_write();
        test_read_first();
        test_out_reg();
        test_back_to_back();
        test_reset_inflight();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sb[i].size() != 0) begin
                errors++;
                $display("FAIL drain_u%0d: %0d reads outstanding, required 0", i, sb[i].size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
